z_relu_packer: RTL

Z_RELU_PACKER -- requirements
Module: z_relu_packer

---
 rtl/z_relu_packer_if.sv | 20 ++
 rtl/z_relu_packer.sv | 113 +++++++++++
 2 files changed

// File: rtl/z_relu_packer_if.sv
// Stream bundle for z_relu_packer: z element strobes in, packed 64-bit words out.
interface z_relu_packer_if;
  logic [15:0] z_vector;
  logic        z_vector_ready;
  logic        finished;
  logic [63:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output z_vector, z_vector_ready, finished, out_ready,
    input  out_word, out_valid, out_last
  );

  modport slave (
    input  z_vector, z_vector_ready, finished, out_ready,
    output out_word, out_valid, out_last
  );
endinterface

// File: rtl/z_relu_packer.sv
// ReLU z elements, pack four 16-bit lanes per word and queue words in a small FIFO.
// A word that arrives while the FIFO is full with no pop is dropped and flagged sticky.
module z_relu_packer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clock,
  input  logic       clear_n,
  z_relu_packer_if.slave bus,
  output logic       overflow,
  output logic [1:0] layer_count
);

  localparam int         PTR_W   = (FIFO_DEPTH == 4) ? 2 : 1;
  localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

  logic [1:0]       lane_r;
  logic [63:0]      acc_r;
  logic [64:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [2:0]       count_r;
  logic             overflow_r;
  logic [1:0]       layer_r;

  logic [15:0] relu_s;
  logic [63:0] filled_s;
  logic [63:0] acc_next_s;
  logic [1:0]  lane_next_s;
  logic        push_s;
  logic        pop_s;
  logic        full_s;
  logic        wr_en_s;
  logic        drop_s;

  // Lane insertion, push/pop decisions and next accumulator state.
  always_comb begin
    relu_s      = bus.z_vector[15] ? 16'h0000 : bus.z_vector;
    filled_s    = acc_r;
    acc_next_s  = acc_r;
    lane_next_s = lane_r;
    if (bus.z_vector_ready) begin
      case (lane_r)
        2'd0:    filled_s[15:0]  = relu_s;
        2'd1:    filled_s[31:16] = relu_s;
        2'd2:    filled_s[47:32] = relu_s;
        2'd3:    filled_s[63:48] = relu_s;
        default: filled_s        = acc_r;
      endcase
    end else begin
      filled_s = acc_r;
    end
    // finished closes the word even when this element lands in lane 3
    push_s  = bus.finished || (bus.z_vector_ready && (lane_r == 2'd3));
    pop_s   = (count_r != 3'd0) && bus.out_ready;
    full_s  = (count_r == DEPTH_C);
    wr_en_s = push_s && (!full_s || pop_s);
    drop_s  = push_s && full_s && !pop_s;
    if (push_s) begin
      acc_next_s  = 64'h0;
      lane_next_s = 2'd0;
    end else if (bus.z_vector_ready) begin
      acc_next_s  = filled_s;
      lane_next_s = lane_r + 2'd1;
    end else begin
      acc_next_s  = acc_r;
      lane_next_s = lane_r;
    end
  end

  // Packer state, FIFO storage/pointers and status counters.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      lane_r     <= 2'd0;
      acc_r      <= 64'h0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= 3'd0;
      overflow_r <= 1'b0;
      layer_r    <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 65'h0;
      end
    end else begin
      lane_r <= lane_next_s;
      acc_r  <= acc_next_s;
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= {bus.finished, filled_s};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (bus.finished) begin
        layer_r <= layer_r + 2'd1;
      end
    end
  end

  assign bus.out_word  = mem_r[rd_ptr_r][63:0];
  assign bus.out_last  = mem_r[rd_ptr_r][64];
  assign bus.out_valid = (count_r != 3'd0);
  assign overflow      = overflow_r;
  assign layer_count   = layer_r;

endmodule
